// File: rtl/dac_spi_pkg.sv
// Shared types and default configuration for the dac_spi SPI master.
package dac_spi_pkg;

    localparam int unsigned WORD_W_DEF  = 16;
    localparam int unsigned CLK_DIV_DEF = 4;
    localparam int unsigned CS_GAP_DEF  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_e;

endpackage

// File: rtl/sclk_tick.sv
// Half-period timebase: one-cycle tick every CLK_DIV cycles while enabled.
module sclk_tick
    import dac_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] CntLast = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if (!enable || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_spi.sv
// SPI mode-0 master for a DAC: one word per frame, MSB first, framed by active-low CS.
// Define DAC_SPI_LDAC_EN to add the active-low LDAC load strobe after each frame.
module dac_spi
    import dac_spi_pkg::*;
#(
    parameter int unsigned WORD_W  = WORD_W_DEF,
    parameter int unsigned CLK_DIV = CLK_DIV_DEF,
    parameter int unsigned CS_GAP  = CS_GAP_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              cs,
    output logic              sclk,
    output logic              mosi,
    output logic              done
`ifdef DAC_SPI_LDAC_EN
    ,
    output logic              ldac
`endif
);

    localparam int unsigned BCW = $clog2(WORD_W + 1);
    localparam int unsigned GCW = $clog2(CS_GAP + 1);
    localparam logic [BCW-1:0] BitLast   = BCW'(WORD_W);
    localparam logic [GCW-1:0] GapLast   = GCW'(CS_GAP);
    localparam logic [GCW-1:0] GapLastM1 = GCW'(CS_GAP - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GCW-1:0]    gap_cnt_q, gap_cnt_d;
    logic              sclk_q, sclk_d;
    logic              done_q, done_d;
    logic              run_q;
    logic              tick;
    logic              tick_en;
    logic              in_frame;
    logic              ldac_idle;

    // The DONE cycle sits ahead of the gap count, so the timebase restarts after it.
    assign tick_en = (state_q != StIdle) && !done_q;

    sclk_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_tick (
        .clock (clock),
        .reset (reset),
        .enable(tick_en),
        .tick  (tick)
    );

    assign in_frame = (state_q == StSetup) || (state_q == StShift) || (state_q == StHold);
    assign cs       = !in_frame;
    assign sclk     = sclk_q;
    assign mosi     = in_frame && shreg_q[WORD_W-1];
    assign ready    = run_q && (state_q == StIdle);
    assign done     = done_q;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sclk_d    = sclk_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                gap_cnt_d = '0;
                if (valid && ready) begin
                    shreg_d = data_in;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                // Each bit is a high half then a low half; shift on the falling edge.
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d    = 1'b0;
                        shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (bit_cnt_q == BitLast) begin
                        state_d = StHold;
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    state_d = StGap;
                    done_d  = 1'b1;
                end
            end
            StGap: begin
                if (tick && (gap_cnt_q != GapLast)) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
                if (((gap_cnt_q == GapLast) || (tick && (gap_cnt_q == GapLastM1))) && ldac_idle) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sclk_q    <= 1'b0;
            done_q    <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sclk_q    <= sclk_d;
            done_q    <= done_d;
            run_q     <= 1'b1;
        end
    end

`ifdef DAC_SPI_LDAC_EN
    localparam int unsigned CDW = $clog2(CLK_DIV + 1);
    localparam logic [CDW-1:0] LdacLast = CDW'(CLK_DIV - 1);

    logic           ldac_q, ldac_d;
    logic [CDW-1:0] ldac_cnt_q, ldac_cnt_d;

    assign ldac      = ldac_q;
    assign ldac_idle = ldac_q && !done_q;

    always_comb begin
        ldac_d     = ldac_q;
        ldac_cnt_d = ldac_cnt_q;
        if (done_q) begin
            ldac_d     = 1'b0;
            ldac_cnt_d = '0;
        end else if (!ldac_q) begin
            if (ldac_cnt_q == LdacLast) begin
                ldac_d     = 1'b1;
                ldac_cnt_d = '0;
            end else begin
                ldac_cnt_d = ldac_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ldac_q     <= 1'b1;
            ldac_cnt_q <= '0;
        end else begin
            ldac_q     <= ldac_d;
            ldac_cnt_q <= ldac_cnt_d;
        end
    end
`else
    assign ldac_idle = 1'b1;
`endif

endmodule
